pipe_hazard_ctrl: RTL and testbench
===================================

Name: pipe_hazard_ctrl

Overview:
- Pipeline controller for the 5-stage MIPS core. Generates PC and pipeline-register enables, flushes and bubbles for IF_ID, ID_EX, EX_MEM and MEM_WB.
- Detects load-use hazards, flushes the pipeline on taken branches and jumps, and drives EX-stage forwarding selects.
- Sequences multi-cycle data-memory accesses through a req/ready handshake with a timeout.
- Sits beside the datapath and consumes the dst/ctrl fields already carried by the stage registers.

Parameters:
MEM_TIMEOUT, 16, max cycles in MEM_WAIT before halting (must be 1..255)
CNT_W, 32, width of stall performance counter

Ports:
clk  in  1  clock, all state on posedge
reset  in  1  synchronous, active-high
id_rs  in  5  rs field of instruction in ID
id_rt  in  5  rt field of instruction in ID
id_uses_rt  in  1  ID instruction reads rt
id_branch_taken  in  1  branch/jump resolved taken in ID
ex_rs  in  5  rs held in ID_EX
ex_rt  in  5  rt held in ID_EX
ex_dst  in  5  destination held in ID_EX
ex_MemRead  in  1  ID_EX instruction is a load
mem_dst  in  5  destination held in EX_MEM
mem_RegWrite  in  1  EX_MEM writes a register
mem_MemRead  in  1  EX_MEM is a load
mem_MemWrite  in  1  EX_MEM is a store
mem_ready  in  1  data memory completes access this cycle
wb_dst  in  5  dstOut of MEM_WB
wb_RegWrite  in  1  RegWrite of MEM_WB
pc_en  out  1  PC update enable
ifid_en  out  1  IF_ID load enable
ifid_flush  out  1  IF_ID clear to nop
idex_en  out  1  ID_EX load enable
idex_flush  out  1  ID_EX load bubble (all ctrl zero)
exmem_en  out  1  EX_MEM load enable
memwb_bubble  out  1  MEM_WB loads CtrlSig=0 (RegWrite=0, MemtoReg=0)
mem_req  out  1  data memory request
fwd_a  out  2  ALU A select: 00 regfile, 10 EX_MEM, 01 MEM_WB
fwd_b  out  2  ALU B select, same encoding
mem_err  out  1  sticky timeout error
stall_cnt  out  CNT_W  cycles with pc_en=0

Behaviour:
- FSM states: RUN, MEM_WAIT, HALT. Reset -> RUN, wait_cnt=0, mem_err=0, stall_cnt=0.
- Register outputs during reset: mem_err=0, stall_cnt=0. Combinational outputs follow the RUN equations.
- mem_acc = mem_MemRead | mem_MemWrite.
- mem_req = (RUN & mem_acc) | MEM_WAIT.
- freeze = (RUN & mem_acc & !mem_ready) | (MEM_WAIT & !mem_ready) | HALT.
- freeze=1 -> pc_en=ifid_en=idex_en=exmem_en=0, memwb_bubble=1, ifid_flush=idex_flush=0.
- RUN -> MEM_WAIT when mem_acc & !mem_ready. Otherwise stay in RUN.
- MEM_WAIT:
  - mem_ready=1: unfreeze that same cycle, wait_cnt<=0, return to RUN.
  - otherwise wait_cnt++.
  - wait_cnt==MEM_TIMEOUT-1 & !mem_ready: -> HALT, mem_err<=1.
- HALT is left only by reset. mem_err stays 1 until reset.
- Load-use (evaluated only when freeze=0): lu = ex_MemRead & ex_dst!=0 & (ex_dst==id_rs | (id_uses_rt & ex_dst==id_rt)).
  - lu=1 -> pc_en=0, ifid_en=0, idex_flush=1. exmem_en=1, memwb_bubble=0.
- Branch: id_branch_taken & !lu & !freeze -> ifid_flush=1, and all enables stay 1.
  - With lu=1 the branch is ignored. It is re-resolved next cycle once the operand is available.
- Priority: reset > freeze > lu > branch.
- Default (no event): all enables 1, flushes 0, memwb_bubble 0.
- Forwarding (combinational, independent of freeze), fwd_a:
  - 10 if mem_RegWrite & mem_dst!=0 & mem_dst==ex_rs;
  - else 01 if wb_RegWrite & wb_dst!=0 & wb_dst==ex_rs;
  - else 00.
  - fwd_b identical using ex_rt. EX_MEM wins over MEM_WB.
- stall_cnt increments on every cycle with pc_en=0 (freeze or lu) and saturates at all-ones.
- Register $0 never triggers a hazard or a forward.

Test Plan:
- Reset then idle, all ctrl inputs 0 -> pc_en=ifid_en=idex_en=exmem_en=1, flushes=0, fwd_a=fwd_b=00, stall_cnt=0, mem_err=0.
- Load-use: ex_MemRead=1, ex_dst=5, id_rs=5 for one cycle -> pc_en=0, ifid_en=0, idex_flush=1 that cycle, stall_cnt=1. Same stimulus with ex_dst=0 -> no stall.
- Load-use plus id_branch_taken=1 in the same cycle -> ifid_flush=0, stall only. Next cycle with ex_MemRead=0 and branch still taken -> ifid_flush=1.
- mem_MemRead=1, mem_ready low for 3 cycles then high -> mem_req=1 for 4 cycles, freeze for 3, memwb_bubble=1 for 3, RUN after the 4th cycle, stall_cnt=3.
- mem_MemWrite=1, mem_ready held 0, MEM_TIMEOUT=16 -> HALT, mem_err=1 after 17 cycles, all enables stay 0. Reset asserted in HALT -> RUN, mem_err=0, stall_cnt=0 next cycle.
- Forwarding: mem_RegWrite=1, mem_dst=7; wb_RegWrite=1, wb_dst=7; ex_rs=7, ex_rt=7 -> fwd_a=fwd_b=10. Change mem_dst to 3 -> fwd_a=fwd_b=01. Set wb_dst=0 -> fwd_a=fwd_b=00.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage MIPS core: stage enables/flushes,
// load-use stalls, branch flushes, EX forwarding selects and data-memory wait sequencing.
module pipe_hazard_ctrl #(
   parameter int MEM_TIMEOUT = 16,
   parameter int CNT_W       = 32
) (
   input  logic             clk,
   input  logic             reset,
   input  logic [4:0]       id_rs,
   input  logic [4:0]       id_rt,
   input  logic             id_uses_rt,
   input  logic             id_branch_taken,
   input  logic [4:0]       ex_rs,
   input  logic [4:0]       ex_rt,
   input  logic [4:0]       ex_dst,
   input  logic             ex_MemRead,
   input  logic [4:0]       mem_dst,
   input  logic             mem_RegWrite,
   input  logic             mem_MemRead,
   input  logic             mem_MemWrite,
   input  logic             mem_ready,
   input  logic [4:0]       wb_dst,
   input  logic             wb_RegWrite,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             ifid_flush,
   output logic             idex_en,
   output logic             idex_flush,
   output logic             exmem_en,
   output logic             memwb_bubble,
   output logic             mem_req,
   output logic [1:0]       fwd_a,
   output logic [1:0]       fwd_b,
   output logic             mem_err,
   output logic [CNT_W-1:0] stall_cnt
);

   typedef enum logic [1:0] {RUN, MEM_WAIT, HALT} state_t;

   state_t     state;
   logic [7:0] waitCnt;
   logic       inRun, inWait, inHalt;
   logic       memAcc, freeze, loadUse;

   // While reset is held the combinational outputs behave as in RUN.
   assign inRun  = reset || (state == RUN);
   assign inWait = !reset && (state == MEM_WAIT);
   assign inHalt = !reset && (state == HALT);

   assign memAcc  = mem_MemRead | mem_MemWrite;
   assign mem_req = (inRun & memAcc) | inWait;
   assign freeze  = (inRun & memAcc & !mem_ready) | (inWait & !mem_ready) | inHalt;

   assign loadUse = ex_MemRead && (ex_dst != 5'd0) &&
                    ((ex_dst == id_rs) || (id_uses_rt && (ex_dst == id_rt)));

   always_comb begin
      pc_en        = 1'b1;
      ifid_en      = 1'b1;
      ifid_flush   = 1'b0;
      idex_en      = 1'b1;
      idex_flush   = 1'b0;
      exmem_en     = 1'b1;
      memwb_bubble = 1'b0;
      if (freeze) begin
         pc_en        = 1'b0;
         ifid_en      = 1'b0;
         idex_en      = 1'b0;
         exmem_en     = 1'b0;
         memwb_bubble = 1'b1;
      end else if (loadUse) begin
         pc_en      = 1'b0;
         ifid_en    = 1'b0;
         idex_flush = 1'b1;
      end else if (id_branch_taken) begin
         ifid_flush = 1'b1;
      end
   end

   // EX_MEM result is newer than MEM_WB, so it takes precedence.
   function automatic logic [1:0] fwdSel(input logic [4:0] src);
      if (mem_RegWrite && (mem_dst != 5'd0) && (mem_dst == src))
         return 2'b10;
      else if (wb_RegWrite && (wb_dst != 5'd0) && (wb_dst == src))
         return 2'b01;
      else
         return 2'b00;
   endfunction

   assign fwd_a = fwdSel(ex_rs);
   assign fwd_b = fwdSel(ex_rt);

   always_ff @(posedge clk) begin
      if (reset) begin
         state     <= RUN;
         waitCnt   <= 8'd0;
         mem_err   <= 1'b0;
         stall_cnt <= '0;
      end else begin
         if (!pc_en && (stall_cnt != {CNT_W{1'b1}}))
            stall_cnt <= stall_cnt + 1'b1;
         case (state)
            RUN: begin
               if (memAcc && !mem_ready) begin
                  state   <= MEM_WAIT;
                  waitCnt <= 8'd0;
               end
            end
            MEM_WAIT: begin
               if (mem_ready) begin
                  state   <= RUN;
                  waitCnt <= 8'd0;
               end else if (waitCnt == 8'(MEM_TIMEOUT - 1)) begin
                  state   <= HALT;
                  mem_err <= 1'b1;
               end else begin
                  waitCnt <= waitCnt + 8'd1;
               end
            end
            HALT:    state <= HALT;
            default: state <= RUN;
         endcase
      end
   end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: a cycle model checked every negedge plus literal expectations.
module tb_pipe_hazard_ctrl;
   localparam int TMO = 16;

   logic clk = 1'b0, reset = 1'b1;
   logic [4:0] id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst;
   logic id_uses_rt, id_branch_taken, ex_MemRead, mem_RegWrite, mem_MemRead;
   logic mem_MemWrite, mem_ready, wb_RegWrite;
   logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en, memwb_bubble, mem_req;
   logic [1:0] fwd_a, fwd_b;
   logic mem_err;
   logic [31:0] stall_cnt;

   int nChecks = 0, nFails = 0;
   bit chkEn = 0;

   pipe_hazard_ctrl #(.MEM_TIMEOUT(TMO), .CNT_W(32)) dut (
      .clk(clk), .reset(reset), .id_rs(id_rs), .id_rt(id_rt), .id_uses_rt(id_uses_rt),
      .id_branch_taken(id_branch_taken), .ex_rs(ex_rs), .ex_rt(ex_rt), .ex_dst(ex_dst),
      .ex_MemRead(ex_MemRead), .mem_dst(mem_dst), .mem_RegWrite(mem_RegWrite),
      .mem_MemRead(mem_MemRead), .mem_MemWrite(mem_MemWrite), .mem_ready(mem_ready),
      .wb_dst(wb_dst), .wb_RegWrite(wb_RegWrite), .pc_en(pc_en), .ifid_en(ifid_en),
      .ifid_flush(ifid_flush), .idex_en(idex_en), .idex_flush(idex_flush),
      .exmem_en(exmem_en), .memwb_bubble(memwb_bubble), .mem_req(mem_req),
      .fwd_a(fwd_a), .fwd_b(fwd_b), .mem_err(mem_err), .stall_cnt(stall_cnt));

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Model: memory access outstanding, cycles spent waiting, halted, error, stalls.
   bit mWaiting = 0, mHalted = 0, mErr = 0;
   int mWaitCycles = 0;
   logic [31:0] mStalls = 0;

   // Expected control bundle {pc,ifid,ifidFl,idex,idexFl,exmem,bubble,req}.
   function automatic logic [7:0] expCtrl();
      bit waiting = !reset && mWaiting;
      bit halted  = !reset && mHalted;
      bit acc     = mem_MemRead || mem_MemWrite;
      bit req     = halted ? 0 : (waiting ? 1 : acc);
      bit stuck   = halted || ((waiting || acc) && !mem_ready);
      bit hazard  = ex_MemRead && ex_dst != 0 &&
                    (ex_dst == id_rs || (id_uses_rt && ex_dst == id_rt));
      if (stuck)  return {7'b0000001, req};
      if (hazard) return {7'b0001110, req};
      if (id_branch_taken) return {7'b1111010, req};
      return {7'b1101010, req};
   endfunction

   function automatic logic [1:0] expFwd(input logic [4:0] r);
      if (r == 0) return 2'b00;
      if (mem_RegWrite && mem_dst == r) return 2'b10;
      if (wb_RegWrite && wb_dst == r) return 2'b01;
      return 2'b00;
   endfunction

   always @(posedge clk) begin
      logic [7:0] c;
      c = expCtrl();
      if (reset) begin
         mWaiting = 0; mHalted = 0; mErr = 0; mWaitCycles = 0; mStalls = 0;
      end else begin
         if (!c[7] && mStalls != 32'hFFFF_FFFF) mStalls = mStalls + 1;
         if (mHalted) begin
         end else if (mWaiting) begin
            if (mem_ready) mWaiting = 0;
            else begin
               mWaitCycles++;
               if (mWaitCycles == TMO) begin mHalted = 1; mErr = 1; mWaiting = 0; end
            end
         end else if ((mem_MemRead || mem_MemWrite) && !mem_ready) begin
            mWaiting = 1; mWaitCycles = 0;
         end
      end
   end

   always @(negedge clk) begin
      if (chkEn) begin
         chk("model ctrl", {pc_en, ifid_en, ifid_flush, idex_en, idex_flush, exmem_en,
                            memwb_bubble, mem_req}, expCtrl());
         chk("model fwd_a", fwd_a, expFwd(ex_rs));
         chk("model fwd_b", fwd_b, expFwd(ex_rt));
         chk("model mem_err", mem_err, mErr);
         chk("model stall_cnt", stall_cnt, mStalls);
      end
   end

   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic clearIn();
      {id_rs, id_rt, ex_rs, ex_rt, ex_dst, mem_dst, wb_dst} = '0;
      {id_uses_rt, id_branch_taken, ex_MemRead, mem_RegWrite, mem_MemRead} = '0;
      {mem_MemWrite, mem_ready, wb_RegWrite} = '0;
   endtask

   initial begin
      clearIn();
      reset = 1;
      tick(); chkEn = 1; tick();
      reset = 0;
      // idle
      @(negedge clk);
      chk("idle enables", {pc_en, ifid_en, idex_en, exmem_en}, 4'hF);
      chk("idle flushes", {ifid_flush, idex_flush, memwb_bubble}, 3'b000);
      chk("idle fwd", {fwd_a, fwd_b}, 4'b0000);
      chk("reset stall_cnt", stall_cnt, 0);
      chk("reset mem_err", mem_err, 0);
      tick();
      // load-use
      ex_MemRead = 1; ex_dst = 5; id_rs = 5;
      @(negedge clk);
      chk("lu stall", {pc_en, ifid_en, idex_flush, exmem_en}, 4'b0011);
      tick();
      chk("lu stall_cnt", stall_cnt, 1);
      ex_dst = 0; id_rs = 0;
      @(negedge clk);
      chk("lu r0 no stall", {pc_en, idex_flush}, 2'b10);
      tick();
      // load-use on rt only counts when rt is used
      ex_dst = 9; id_rt = 9; id_uses_rt = 0;
      @(negedge clk); chk("rt unused", pc_en, 1);
      id_uses_rt = 1;
      #1 chk("rt used", pc_en, 0);
      tick();
      chk("rt stall_cnt", stall_cnt, 2);
      // load-use masks branch, branch resolves next cycle
      clearIn(); ex_MemRead = 1; ex_dst = 5; id_rs = 5; id_branch_taken = 1;
      @(negedge clk);
      chk("lu+br flush", {ifid_flush, pc_en}, 2'b00);
      tick();
      ex_MemRead = 0;
      @(negedge clk);
      chk("br flush", {ifid_flush, pc_en, ifid_en}, 3'b111);
      tick();
      chk("br stall_cnt", stall_cnt, 3);
      // multi-cycle load: 3 waits then ready
      clearIn(); mem_MemRead = 1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("mw freeze", {mem_req, memwb_bubble, pc_en, exmem_en}, 4'b1100);
         tick();
      end
      mem_ready = 1;
      @(negedge clk);
      chk("mw release", {mem_req, memwb_bubble, pc_en}, 3'b101);
      tick();
      chk("mw stall_cnt", stall_cnt, 6);
      clearIn();
      @(negedge clk); chk("mw back to run", {mem_req, pc_en}, 2'b01);
      tick();
      // store timeout
      mem_MemWrite = 1;
      for (int i = 0; i < TMO + 1; i++) begin
         chk("to no err yet", mem_err, 0);
         tick();
      end
      chk("to mem_err", mem_err, 1);
      mem_ready = 1;
      @(negedge clk);
      chk("halt frozen", {pc_en, ifid_en, idex_en, exmem_en, mem_req}, 5'b00000);
      tick(); tick();
      chk("halt sticky err", mem_err, 1);
      clearIn(); reset = 1;
      tick();
      reset = 0;
      chk("post reset err", mem_err, 0);
      chk("post reset stall", stall_cnt, 0);
      @(negedge clk); chk("post reset run", pc_en, 1);
      tick();
      // forwarding
      mem_RegWrite = 1; mem_dst = 7; wb_RegWrite = 1; wb_dst = 7; ex_rs = 7; ex_rt = 7;
      #1 chk("fwd exmem", {fwd_a, fwd_b}, 4'b1010);
      mem_dst = 3;
      #1 chk("fwd memwb", {fwd_a, fwd_b}, 4'b0101);
      ex_rt = 3;
      #1 chk("fwd mixed", {fwd_a, fwd_b}, 4'b0110);
      wb_dst = 0; ex_rt = 7;
      #1 chk("fwd none", {fwd_a, fwd_b}, 4'b0000);
      mem_dst = 0; ex_rs = 0; mem_RegWrite = 1;
      #1 chk("fwd r0", fwd_a, 2'b00);
      tick(); tick();
      chkEn = 0;
      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end
endmodule
